// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns; latency 4/COLS_PER_CYCLE cycles from accept to out_valid.
// Single-entry: in_ready only in IDLE, result held in DONE until out_ready.

// Combinational GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
module poly_mul (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic [7:0] acc;
  logic [7:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    p = acc;
  end
endmodule

module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;

  logic [31:0]  cols     [4];
  logic [31:0]  cols_nxt [4];
  logic [31:0]  lane_in  [COLS_PER_CYCLE];
  logic [31:0]  lane_out [COLS_PER_CYCLE];
  logic [7:0]   prod     [COLS_PER_CYCLE][4][4];

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      cols[c] = work_q[127-32*c -: 32];
    end
  end

  always_comb begin
    for (int l = 0; l < COLS_PER_CYCLE; l++) begin
      lane_in[l] = cols[col_q + 2'(l)];
    end
  end

  // Row r of the inverse matrix is {0e,0b,0d,09} rotated right by r.
  for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
    for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar k = 0; k < 4; k++) begin : g_term
        poly_mul u_mul (
          .a (lane_in[l][31-8*k -: 8]),
          .b (COEF[(k - r + 4) % 4]),
          .p (prod[l][r][k])
        );
      end
      assign lane_out[l][31-8*r -: 8] =
        prod[l][r][0] ^ prod[l][r][1] ^ prod[l][r][2] ^ prod[l][r][3];
    end
  end

  always_comb begin
    cols_nxt = cols;
    for (int l = 0; l < COLS_PER_CYCLE; l++) begin
      cols_nxt[col_q + 2'(l)] = lane_out[l];
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          col_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = {cols_nxt[0], cols_nxt[1], cols_nxt[2], cols_nxt[3]};
        col_d  = col_q + 2'(COLS_PER_CYCLE);
        if (3'(col_q) + 3'(COLS_PER_CYCLE) == 3'd4) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = work_q;
endmodule
